// File: rtl/hs_receiver.sv
// hs_receiver: receiving side of an 8-bit four-phase req/ack handshake.
//
// Synchronises the asynchronous `req`, captures the bundled `data` into a
// local FIFO once per handshake, and answers with a registered `ack`. While
// the FIFO is full a new request is not accepted; this throttles the sender.
// A consumer drains the FIFO through a first-word-fall-through pop port.
//
// Optional feature (macro HS_RECEIVER_SEQ_CHECK_EN): when defined, every
// stored byte must equal the previous stored byte + 1 (mod 256). A mismatch
// sets the sticky `seq_err`. When the macro is undefined, `seq_err` is tied
// low and no compare logic is built.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   req       in   request from sender (asynchronous to clk)
//   data      in   8-bit sender data, stable while req=1
//   ack       out  registered acknowledge to sender
//   rd_en     in   consumer pop, ignored while empty
//   dout      out  FIFO head, valid while empty=0
//   empty     out  FIFO empty
//   full      out  FIFO full
//   count     out  FIFO occupancy (AW+1 bits)
//   rx_total  out  bytes accepted since reset, wraps at 16 bits
//   seq_err   out  sticky sequence error (optional feature)

module hs_receiver #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AW          = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [7:0]    data,
  output logic          ack,
  input  logic          rd_en,
  output logic [7:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic [15:0]   rx_total,
  output logic          seq_err
);

  typedef enum logic [1:0] {
    WAIT_REQ = 2'd0,
    STORE    = 2'd1,
    ACK_HI   = 2'd2
  } state_t;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  state_t                 state_r;
  state_t                 state_next_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   req_s;
  logic                   ack_r;
  logic [7:0]             mem_r [DEPTH];
  logic [AW-1:0]          wr_ptr_r;
  logic [AW-1:0]          rd_ptr_r;
  logic [AW:0]            count_r;
  logic [15:0]            rx_total_r;
  logic                   wr_s;
  logic                   rd_s;
  logic                   empty_s;
  logic                   full_s;

  assign req_s   = sync_r[SYNC_STAGES-1];
  assign empty_s = (count_r == {(AW+1){1'b0}});
  assign full_s  = (count_r == FULL_COUNT);
  // The write happens on the edge that leaves STORE; entry to STORE is gated
  // by full, so a write into a full FIFO cannot occur.
  assign wr_s    = (state_r == STORE);
  assign rd_s    = rd_en && !empty_s;

  assign ack      = ack_r;
  assign dout     = mem_r[rd_ptr_r];
  assign empty    = empty_s;
  assign full     = full_s;
  assign count    = count_r;
  assign rx_total = rx_total_r;

  // Multi-flop synchroniser for the asynchronous request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], req};
    end
  end

  // Handshake FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= WAIT_REQ;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Handshake FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      WAIT_REQ: begin
        // A request seen while full is left pending: no capture, no ack.
        if (req_s && !full_s) begin
          state_next_s = STORE;
        end else begin
          state_next_s = WAIT_REQ;
        end
      end
      STORE: begin
        // Always completes the cycle, even if req already dropped.
        state_next_s = ACK_HI;
      end
      ACK_HI: begin
        if (req_s) begin
          state_next_s = ACK_HI;
        end else begin
          state_next_s = WAIT_REQ;
        end
      end
      default: begin
        state_next_s = WAIT_REQ;
      end
    endcase
  end

  // Registered acknowledge, high exactly while the FSM sits in ACK_HI.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_r <= 1'b0;
    end else begin
      ack_r <= (state_next_s == ACK_HI);
    end
  end

  // FIFO pointers and occupancy; simultaneous write and pop leave count as is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (wr_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_s, rd_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (wr_s) begin
      mem_r[wr_ptr_r] <= data;
    end
  end

  // Count of accepted bytes, wrapping naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_total_r <= 16'h0000;
    end else if (wr_s) begin
      rx_total_r <= rx_total_r + 16'h0001;
    end
  end

`ifdef HS_RECEIVER_SEQ_CHECK_EN
  logic [7:0] last_r;
  logic       seeded_r;
  logic       seq_err_r;

  assign seq_err = seq_err_r;

  // Sequence checker: the first byte only seeds the reference value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_r    <= 8'h00;
      seeded_r  <= 1'b0;
      seq_err_r <= 1'b0;
    end else if (wr_s) begin
      last_r   <= data;
      seeded_r <= 1'b1;
      if (seeded_r && (data != (last_r + 8'h01))) begin
        seq_err_r <= 1'b1;
      end
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_hs_receiver.sv
// Self-checking bench for hs_receiver: directed steps plus a randomized
// phase, compared against a queue-based reference model of the receiver.
module tb_hs_receiver;
  localparam int DEPTH       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int AW          = 2;
`ifdef HS_RECEIVER_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [7:0]  data;
  logic        ack;
  logic        rd_en;
  logic [7:0]  dout;
  logic        empty;
  logic        full;
  logic [AW:0] count;
  logic [15:0] rx_total;
  logic        seq_err;

  hs_receiver #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES), .AW(AW)) dut (
    .clk(clk), .reset(reset), .req(req), .data(data), .ack(ack),
    .rd_en(rd_en), .dout(dout), .empty(empty), .full(full),
    .count(count), .rx_total(rx_total), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [7:0]  q[$];
  logic [15:0] m_total;
  logic [7:0]  m_last;
  bit          m_seeded;
  bit          m_seq_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_total   = 16'h0000;
    m_last    = 8'h00;
    m_seeded  = 1'b0;
    m_seq_bad = 1'b0;
  endtask

  task automatic model_store(input logic [7:0] d);
    q.push_back(d);
    m_total = m_total + 16'h0001;
    if (m_seeded && (d != m_last + 8'h01)) m_seq_bad = 1'b1;
    m_last   = d;
    m_seeded = 1'b1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "/count"}, 32'(count), 32'(q.size()));
    check({tag, "/empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, "/full"}, 32'(full), 32'(q.size() == DEPTH));
    check({tag, "/rx_total"}, 32'(rx_total), 32'(m_total));
    check({tag, "/seq_err"}, 32'(seq_err), 32'(SEQ_EN && m_seq_bad));
    if (q.size() > 0) check({tag, "/dout"}, 32'(dout), 32'(q[0]));
  endtask

  // Wait (bounded) for ack to reach val; n = edges waited.
  task automatic wait_ack(input logic val, input int max, output int n);
    n = 0;
    while (ack !== val && n < max) begin
      tick();
      n++;
    end
  endtask

  // One full four-phase handshake, holding req for `hold` extra cycles.
  task automatic send(input logic [7:0] d, input int hold);
    int n;
    data = d;
    req  = 1'b1;
    wait_ack(1'b1, 40, n);
    check("send/ack_hi", 32'(ack), 32'd1);
    model_store(d);
    repeat (hold) tick();
    check_state("send/held");
    req = 1'b0;
    wait_ack(1'b0, 40, n);
    check("send/ack_lo", 32'(ack), 32'd0);
  endtask

  task automatic pop();
    if (q.size() > 0) check("pop/head", 32'(dout), 32'(q[0]));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    tick();
    model_reset();
  endtask

  initial begin
    int n;
    int hi;
    logic [7:0] d;
    reset = 1'b1;
    req   = 1'b0;
    rd_en = 1'b0;
    data  = 8'h00;
    model_reset();
    #1;
    check("reset/ack", 32'(ack), 32'd0);
    check("reset/dout", 32'(dout), 32'd0);
    check_state("reset");
    #21 reset = 1'b0;
    tick();

    // Reset asserted mid-ACK_HI: ack drops immediately.
    data = 8'hAA;
    req  = 1'b1;
    wait_ack(1'b1, 40, n);
    check("rst_mid/ack_before", 32'(ack), 32'd1);
    #3 reset = 1'b1;
    #1;
    check("rst_mid/ack_async", 32'(ack), 32'd0);
    req = 1'b0;
    #2 reset = 1'b0;
    tick();
    model_reset();
    check_state("rst_mid/after");

    // Single handshake with latency checks.
    data = 8'h05;
    req  = 1'b1;
    wait_ack(1'b1, 20, n);
    check("lat/rise", 32'(n), 32'(SYNC_STAGES + 2));
    model_store(8'h05);
    check_state("single");
    req = 1'b0;
    wait_ack(1'b0, 20, n);
    check("lat/fall", 32'(n), 32'(SYNC_STAGES + 1));
    check_state("single/done");
    pop();
    check_state("single/popped");

    // Back-pressure while full.
    for (int i = 1; i <= 4; i++) send(8'(i), 0);
    check_state("bp/full");
    data = 8'h05;
    req  = 1'b1;
    repeat (10) tick();
    check("bp/ack_withheld", 32'(ack), 32'd0);
    check_state("bp/stalled");
    pop();
    wait_ack(1'b1, 40, n);
    check("bp/ack_after_pop", 32'(ack), 32'd1);
    model_store(8'h05);
    req = 1'b0;
    wait_ack(1'b0, 40, n);
    check_state("bp/accepted");
    while (q.size() > 0) pop();
    check_state("bp/drained");

    // Simultaneous STORE write and pop with count=2.
    send(8'h31, 0);
    send(8'h32, 0);
    data = 8'h33;
    req  = 1'b1;
    repeat (SYNC_STAGES + 1) tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("simul/ack", 32'(ack), 32'd1);
    void'(q.pop_front());
    model_store(8'h33);
    check_state("simul");
    req = 1'b0;
    wait_ack(1'b0, 40, n);
    while (q.size() > 0) pop();

    // Protocol violation: req drops before ack; one ack pulse, byte stored.
    data = 8'h77;
    req  = 1'b1;
    tick();
    req = 1'b0;
    hi  = 0;
    repeat (8) begin
      tick();
      if (ack === 1'b1) hi++;
    end
    check("viol/pulse", 32'(hi), 32'd1);
    model_store(8'h77);
    check_state("viol");
    pop();

    // Wrap: 10 bytes, each popped on arrival, from a fresh reset.
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      send(8'(i), 0);
      pop();
    end
    check_state("wrap/end");
    check("wrap/rx_total", 32'(rx_total), 32'd10);

    // Randomized traffic with random req hold and random pops.
    for (int i = 0; i < 30; i++) begin
      d = 8'($urandom_range(0, 255));
      if (q.size() == DEPTH) pop();
      send(d, int'($urandom_range(0, 3)));
      check_state("rand/send");
      if ($urandom_range(0, 1) == 1 && q.size() > 0) pop();
      check_state("rand/pop");
    end

    // Sequence check: FE, FF, 00 legal; 02 breaks the sequence.
    pulse_reset();
    check_state("seq/reset");
    send(8'hFE, 0); pop();
    send(8'hFF, 0); pop();
    send(8'h00, 0); pop();
    check_state("seq/legal");
    send(8'h02, 0); pop();
    check_state("seq/broken");
    send(8'h03, 0); pop();
    check_state("seq/held");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
